// File: rtl/nic_output_port_lookup_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nic_output_port_lookup_pkg : shared constants and state encoding
// Rev 1.0
// ---------------------------------------------------------------------------
package nic_output_port_lookup_pkg;

  localparam logic [7:0] IOQ_STAGE_NUM = 8'hFF;

  // IO-queue module header field positions; every field is 16 bits wide
  localparam int PORT_FIELD_W = 16;
  localparam int DST_PORT_POS = 48;
  localparam int WORD_LEN_POS = 32;
  localparam int SRC_PORT_POS = 16;
  localparam int BYTE_LEN_POS = 0;

  typedef enum logic [0:0] {
    MODULE_HDRS = 1'b0,
    IN_PKT      = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/fallthrough_small_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fallthrough_small_fifo : first-word-fall-through FIFO with nearly_full
// Rev 1.0
// ---------------------------------------------------------------------------
module fallthrough_small_fifo #(
  parameter int WIDTH          = 72,
  parameter int MAX_DEPTH_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             nearly_full,
  output logic             empty
);

  localparam int DEPTH = 1 << MAX_DEPTH_BITS;
  localparam logic [MAX_DEPTH_BITS:0] FULL_LEVEL = (MAX_DEPTH_BITS+1)'(DEPTH);
  localparam logic [MAX_DEPTH_BITS:0] NF_LEVEL   = (MAX_DEPTH_BITS+1)'(DEPTH - 2);

  logic [WIDTH-1:0]          mem_q [DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [MAX_DEPTH_BITS:0]   count_q, count_d;
  logic                      do_wr;
  logic                      do_rd;
  logic                      full;

  assign full        = (count_q == FULL_LEVEL);
  assign empty       = (count_q == '0);
  // Deasserts with two slots still free so a registered upstream can land one more word
  assign nearly_full = (count_q > NF_LEVEL);
  assign dout        = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && (!full || rd_en);
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/nic_output_port_lookup.sv
`default_nettype none
// ---------------------------------------------------------------------------
// nic_output_port_lookup : rewrites IO-queue header dst_port from src_port
// Rev 1.0
// ---------------------------------------------------------------------------
module nic_output_port_lookup #(
  parameter int         DATA_WIDTH      = 64,
  parameter int         CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int         NUM_MAC_PORTS   = 4,
  parameter logic [7:0] IOQ_STAGE_NUM   = nic_output_port_lookup_pkg::IOQ_STAGE_NUM,
  parameter int         FIFO_DEPTH_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  hub_mode,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           drop_cnt
);

  import nic_output_port_lookup_pkg::*;

  localparam int NUM_PORTS = 2 * NUM_MAC_PORTS;
  localparam logic [CTRL_WIDTH-1:0] IOQ_CTRL = CTRL_WIDTH'(IOQ_STAGE_NUM);

  // MAC i <-> CPU i in NIC mode; MAC floods other MACs in hub mode
  function automatic logic [PORT_FIELD_W-1:0] map_dst(input logic [PORT_FIELD_W-1:0] src,
                                                       input logic                    hub);
    logic [PORT_FIELD_W-1:0] dst;
    dst = '0;
    if (src < PORT_FIELD_W'(NUM_PORTS)) begin
      if (src[0]) begin
        dst = PORT_FIELD_W'(1) << (src - 1'b1);
      end else if (!hub) begin
        dst = PORT_FIELD_W'(1) << (src + 1'b1);
      end else begin
        for (int i = 0; i < NUM_PORTS; i += 2) begin
          if (PORT_FIELD_W'(i) != src) dst[i] = 1'b1;
        end
      end
    end
    return dst;
  endfunction

  logic [DATA_WIDTH+CTRL_WIDTH-1:0] fifo_dout;
  logic                             fifo_empty;
  logic                             fifo_nearly_full;
  logic                             pop;
  logic [DATA_WIDTH-1:0]            word_data;
  logic [CTRL_WIDTH-1:0]            word_ctrl;
  logic [PORT_FIELD_W-1:0]          word_src;
  logic                             is_ioq_hdr;

  state_e                state_q, state_d;
  logic                  out_wr_q, out_wr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;

  fallthrough_small_fifo #(
    .WIDTH          (DATA_WIDTH + CTRL_WIDTH),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_input_fifo (
    .clk         (clk),
    .reset       (reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (in_wr),
    .rd_en       (pop),
    .dout        (fifo_dout),
    .nearly_full (fifo_nearly_full),
    .empty       (fifo_empty)
  );

  assign in_rdy     = !fifo_nearly_full;
  assign pop        = !fifo_empty && out_rdy;
  assign word_data  = fifo_dout[DATA_WIDTH-1:0];
  assign word_ctrl  = fifo_dout[DATA_WIDTH+CTRL_WIDTH-1:DATA_WIDTH];
  assign word_src   = word_data[SRC_PORT_POS +: PORT_FIELD_W];
  assign is_ioq_hdr = (state_q == MODULE_HDRS) && (word_ctrl == IOQ_CTRL);

  always_comb begin
    state_d    = state_q;
    out_wr_d   = pop;
    out_data_d = out_data_q;
    out_ctrl_d = out_ctrl_q;
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pop) begin
      out_ctrl_d = word_ctrl;
      out_data_d = word_data;
      if (is_ioq_hdr) begin
        out_data_d[DST_PORT_POS +: PORT_FIELD_W] = map_dst(word_src, hub_mode);
        pkt_cnt_d = pkt_cnt_q + 32'd1;
        if (word_src >= PORT_FIELD_W'(NUM_PORTS)) drop_cnt_d = drop_cnt_q + 32'd1;
      end
      case (state_q)
        MODULE_HDRS: if (word_ctrl == '0) state_d = IN_PKT;
        IN_PKT:      if (word_ctrl != '0) state_d = MODULE_HDRS;
        default:     state_d = MODULE_HDRS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= MODULE_HDRS;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire
